// File: rtl/dlart_console_ctrl.sv
// dlart_console_ctrl: DCJ11 console DLART (RCSR/RBUF/XCSR/XBUF) with RX/TX byte FIFOs.
// Optional feature macro: DLART_IRQ_EN (CSR interrupt enables and rx_irq/tx_irq ports). Rev 1.0
`default_nettype none

module dlart_console_ctrl #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [21:0] BASE_ADDR   = 22'o17777560,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ale_n,
  input  logic        sctl_n,
  input  logic        bufctl_n,
  input  logic [3:0]  aio,
  input  logic [1:0]  bs,
  input  logic [21:0] dal_in,
  output logic [15:0] dal_out,
  output logic        dal_oe,
  output logic        dlart_hit,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ack,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
`ifdef DLART_IRQ_EN
  ,
  output logic        rx_irq,
  output logic        tx_irq
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ADDR = 2'b01;
  localparam logic [1:0] ST_RD   = 2'b10;
  localparam logic [1:0] ST_WR   = 2'b11;

  localparam logic [1:0] SEL_RCSR = 2'b00;
  localparam logic [1:0] SEL_RBUF = 2'b01;
  localparam logic [1:0] SEL_XCSR = 2'b10;
  localparam logic [1:0] SEL_XBUF = 2'b11;

  // Strobe synchronizers; reset to the inactive (high) level so no edge appears at release.
  logic [SYNC_STAGES-1:0] ale_s, sctl_s, bufctl_s;
  logic                   ale_d, sctl_d, bufctl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ale_s    <= '1;
      sctl_s   <= '1;
      bufctl_s <= '1;
      ale_d    <= 1'b1;
      sctl_d   <= 1'b1;
      bufctl_d <= 1'b1;
    end else begin
      ale_s    <= {ale_s[SYNC_STAGES-2:0], ale_n};
      sctl_s   <= {sctl_s[SYNC_STAGES-2:0], sctl_n};
      bufctl_s <= {bufctl_s[SYNC_STAGES-2:0], bufctl_n};
      ale_d    <= ale_s[SYNC_STAGES-1];
      sctl_d   <= sctl_s[SYNC_STAGES-1];
      bufctl_d <= bufctl_s[SYNC_STAGES-1];
    end
  end

  logic ale_fall, ale_rise, sctl_fall, bufctl_rise, bufctl_low;
  assign ale_fall    =  ale_d & ~ale_s[SYNC_STAGES-1];
  assign ale_rise    = ~ale_d &  ale_s[SYNC_STAGES-1];
  assign sctl_fall   =  sctl_d & ~sctl_s[SYNC_STAGES-1];
  assign bufctl_rise = ~bufctl_d & bufctl_s[SYNC_STAGES-1];
  assign bufctl_low  = ~bufctl_s[SYNC_STAGES-1];

  logic [1:0] state;
  logic [1:0] sel_q;
  logic [3:0] aio_q;
  logic       hit_q;
  logic       rd_rbuf_q, rd_pop_q;

  logic rd_enter, wr_enter, rd_exit;
  assign rd_enter = (state == ST_ADDR) && !ale_rise && bufctl_low && aio_q[3] && hit_q;
  assign wr_enter = (state == ST_ADDR) && !ale_rise && sctl_fall && hit_q &&
                    ((aio_q == 4'b0001) || (aio_q == 4'b0011));
  assign rd_exit  = (state == ST_RD) && (ale_rise || bufctl_rise);

  // RX FIFO
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr, rx_rd;
  logic [AW:0] rx_cnt;
  logic        rx_push, rx_pop, rx_nonempty, overrun;

  assign rx_nonempty = (rx_cnt != '0);
  assign rx_pop      = rd_exit && rd_pop_q && rx_nonempty;
  assign rx_push     = rx_valid && ((rx_cnt != FULL_CNT) || rx_pop);

  // TX FIFO
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr, tx_rd;
  logic [AW:0] tx_cnt;
  logic        tx_push, tx_pop, tx_notfull;

  assign tx_notfull = (tx_cnt != FULL_CNT);
  assign tx_pop     = tx_ack && (tx_cnt != '0);
  assign tx_push    = wr_enter && (sel_q == SEL_XBUF) && (tx_notfull || tx_pop);
  assign tx_valid   = (tx_cnt != '0);
  assign tx_data    = tx_valid ? tx_mem[tx_rd] : 8'h00;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= rx_data;
    if (tx_push) tx_mem[tx_wr] <= dal_in[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr   <= '0;
      rx_rd   <= '0;
      rx_cnt  <= '0;
      tx_wr   <= '0;
      tx_rd   <= '0;
      tx_cnt  <= '0;
      overrun <= 1'b0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      if (rx_valid && !rx_push)
        overrun <= 1'b1;
      else if (rd_exit && rd_rbuf_q)
        overrun <= 1'b0;
    end
  end

  logic rx_ie, tx_ie;
`ifdef DLART_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ie  <= 1'b0;
      tx_ie  <= 1'b0;
      rx_irq <= 1'b0;
      tx_irq <= 1'b0;
    end else begin
      if (wr_enter && (sel_q == SEL_RCSR)) rx_ie <= dal_in[6];
      if (wr_enter && (sel_q == SEL_XCSR)) tx_ie <= dal_in[6];
      rx_irq <= rx_nonempty & rx_ie;
      tx_irq <= tx_notfull & tx_ie;
    end
  end
`else
  assign rx_ie = 1'b0;
  assign tx_ie = 1'b0;
`endif

  logic [15:0] rd_mux;
  always_comb begin
    rd_mux = 16'h0000;
    case (sel_q)
      SEL_RCSR: rd_mux = {8'h00, rx_nonempty, rx_ie, 6'b000000};
      SEL_RBUF: rd_mux = {overrun, overrun, 6'b000000, rx_nonempty ? rx_mem[rx_rd] : 8'h00};
      SEL_XCSR: rd_mux = {8'h00, tx_notfull, tx_ie, 6'b000000};
      default:  rd_mux = 16'h0000;
    endcase
  end

  // Bus cycle FSM; synced ale_n rise aborts any state back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sel_q     <= 2'b00;
      aio_q     <= 4'b0000;
      hit_q     <= 1'b0;
      rd_rbuf_q <= 1'b0;
      rd_pop_q  <= 1'b0;
      dal_oe    <= 1'b0;
      dal_out   <= 16'h0000;
    end else begin
      if (ale_rise) begin
        state <= ST_IDLE;
        hit_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (ale_fall) begin
            state <= ST_ADDR;
            sel_q <= dal_in[2:1];
            aio_q <= aio;
            hit_q <= (bs == 2'b10) && (dal_in[21:3] == BASE_ADDR[21:3]) && (aio != 4'b1111);
          end
          ST_ADDR: begin
            if (rd_enter)      state <= ST_RD;
            else if (wr_enter) state <= ST_WR;
          end
          ST_RD:   if (bufctl_rise) state <= ST_ADDR;
          default: state <= state;
        endcase
      end
      if (rd_enter) begin
        dal_oe    <= 1'b1;
        dal_out   <= rd_mux;
        rd_rbuf_q <= (sel_q == SEL_RBUF);
        rd_pop_q  <= (sel_q == SEL_RBUF) && rx_nonempty;
      end else if (rd_exit) begin
        dal_oe    <= 1'b0;
        dal_out   <= 16'h0000;
        rd_rbuf_q <= 1'b0;
        rd_pop_q  <= 1'b0;
      end
    end
  end

  assign dlart_hit = hit_q;

  logic unused_bits;
  assign unused_bits = dal_in[0];

endmodule

`default_nettype wire
